// File: rtl/trivium_seq_ctrl.sv
// Trivium keystream sequencer.
// Accepts a key/IV by handshake, strobes a one-cycle load into the core,
// runs the warm-up rounds, then encrypts/decrypts one data bit per cycle
// through a 1-deep output register. A per-key keystream budget parks the
// controller in EXHAUSTED until a fresh key/IV arrives.
module trivium_seq_ctrl #(
  parameter int unsigned      INIT_ROUNDS = 1152,
  parameter int unsigned      CNT_W       = 64,
  parameter logic [CNT_W-1:0] KS_LIMIT    = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_iv_valid,
  output logic             key_iv_ready,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  output logic             core_load,
  output logic [79:0]      core_key,
  output logic [79:0]      core_iv,
  output logic             core_step,
  input  logic             core_z,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             din,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout,
  input  logic             abort,
  output logic             busy,
  output logic             ks_exhausted,
  output logic [CNT_W-1:0] ks_count
);

  localparam int unsigned      RND_W      = (INIT_ROUNDS > 1) ? $clog2(INIT_ROUNDS) : 1;
  localparam logic [RND_W-1:0] ROUND_LAST = RND_W'(INIT_ROUNDS - 1);
  localparam logic [CNT_W-1:0] KS_LAST    = KS_LIMIT - CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARMUP,
    S_READY,
    S_EXHAUSTED
  } state_t;

  state_t           state_reg, state_next;
  logic [RND_W-1:0] round_reg, round_next;

  logic accept;
  logic din_fire;
  logic dout_fire;

  // Handshake readies. key_iv_ready is held low while in reset so every
  // output reads 0 until the reset is released.
  assign key_iv_ready = rst & ((state_reg == S_IDLE) | (state_reg == S_EXHAUSTED))
                        & ~dout_valid & ~abort;
  assign din_ready    = (state_reg == S_READY) & ~abort & (~dout_valid | dout_ready);

  assign accept    = key_iv_valid & key_iv_ready;
  assign din_fire  = din_valid & din_ready;
  assign dout_fire = dout_valid & dout_ready;

  assign busy         = (state_reg == S_LOAD) | (state_reg == S_WARMUP);
  assign ks_exhausted = (state_reg == S_EXHAUSTED);

  // State and round-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      round_reg <= '0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
    end
  end

  // Next-state logic plus the core strobes; abort overrides everything.
  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state_reg)
      S_IDLE, S_EXHAUSTED: begin
        if (accept) state_next = S_LOAD;
      end
      S_LOAD: begin
        core_load  = 1'b1;
        state_next = S_WARMUP;
        round_next = '0;
      end
      S_WARMUP: begin
        core_step = 1'b1;
        if (round_reg == ROUND_LAST) begin
          state_next = S_READY;
        end else begin
          round_next = round_reg + RND_W'(1);
        end
      end
      S_READY: begin
        if (din_fire) begin
          core_step = 1'b1;
          if (ks_count == KS_LAST) state_next = S_EXHAUSTED;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next = S_IDLE;
      round_next = '0;
      core_load  = 1'b0;
      core_step  = 1'b0;
    end
  end

  // Key/IV capture, keystream accounting and the 1-deep output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_key   <= '0;
      core_iv    <= '0;
      ks_count   <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else if (abort) begin
      ks_count   <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (accept) begin
        core_key <= key;
        core_iv  <= iv;
        ks_count <= '0;
      end
      if (din_fire) begin
        dout       <= din ^ core_z;
        dout_valid <= 1'b1;
        if (ks_count != KS_LIMIT) ks_count <= ks_count + CNT_W'(1);
      end else if (dout_fire) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trivium_seq_ctrl.sv
// Bench for trivium_seq_ctrl: a small instance (4 warm-up rounds, 3-bit
// budget) driven by a pattern-table core, and a full-size instance driven
// by a behavioural Trivium core and checked against a reference keystream.
module tb_trivium_seq_ctrl;

  localparam int IR = 4;
  localparam int CW = 64;
  localparam logic [CW-1:0] LIM = 64'd3;
  localparam int LIM_I = 3;
  localparam int BIG_IR = 1152;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- small instance ----------------
  logic          kiv_valid = 0, kiv_ready;
  logic [79:0]   key = '0, iv = '0;
  logic          core_load, core_step, core_z;
  logic [79:0]   core_key, core_iv;
  logic          din_valid = 0, din_ready, din = 0;
  logic          dout_valid, dout_ready = 0, dout;
  logic          abort = 0, busy, ks_exh;
  logic [CW-1:0] ks_count;

  trivium_seq_ctrl #(.INIT_ROUNDS(IR), .CNT_W(CW), .KS_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .key_iv_valid(kiv_valid), .key_iv_ready(kiv_ready),
    .key(key), .iv(iv), .core_load(core_load), .core_key(core_key),
    .core_iv(core_iv), .core_step(core_step), .core_z(core_z),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .abort(abort), .busy(busy), .ks_exhausted(ks_exh), .ks_count(ks_count)
  );

  // Stand-in core: keystream bit n (counted in steps since load) is zpat[n].
  logic [255:0] zpat;
  logic [7:0]   step_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) step_cnt <= 8'd0;
    else if (core_load) step_cnt <= 8'd0;
    else if (core_step) step_cnt <= step_cnt + 8'd1;
  end
  assign core_z = zpat[step_cnt];

  // ---------------- full-size instance ----------------
  logic          b_kiv_valid = 0, b_kiv_ready;
  logic [79:0]   b_key = '0, b_iv = '0;
  logic          b_core_load, b_core_step, b_core_z;
  logic [79:0]   b_core_key, b_core_iv;
  logic          b_din_valid = 0, b_din_ready, b_din = 0;
  logic          b_dout_valid, b_dout_ready = 0, b_dout;
  logic          b_busy, b_ks_exh;
  logic [63:0]   b_ks_count;

  trivium_seq_ctrl #(.INIT_ROUNDS(BIG_IR), .CNT_W(64)) dut_big (
    .clk(clk), .rst(rst), .key_iv_valid(b_kiv_valid), .key_iv_ready(b_kiv_ready),
    .key(b_key), .iv(b_iv), .core_load(b_core_load), .core_key(b_core_key),
    .core_iv(b_core_iv), .core_step(b_core_step), .core_z(b_core_z),
    .din_valid(b_din_valid), .din_ready(b_din_ready), .din(b_din),
    .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout(b_dout),
    .abort(1'b0), .busy(b_busy), .ks_exhausted(b_ks_exh), .ks_count(b_ks_count)
  );

  // Trivium state s1..s288 is held in bits 0..287.
  function automatic logic [287:0] tri_load(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s = '0;
    s[79:0]    = k;
    s[172:93]  = v;
    s[287:285] = 3'b111;
    return s;
  endfunction

  function automatic logic tri_z(input logic [287:0] s);
    return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
  endfunction

  function automatic logic [287:0] tri_next(input logic [287:0] s);
    logic t1, t2, t3;
    logic [287:0] n;
    t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
    t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
    t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
    n[92:0]    = {s[91:0], t3};
    n[176:93]  = {s[175:93], t1};
    n[287:177] = {s[286:177], t2};
    return n;
  endfunction

  logic [287:0] b_ts;
  always @(posedge clk or negedge rst) begin
    if (!rst) b_ts <= '0;
    else if (b_core_load) b_ts <= tri_load(b_core_key, b_core_iv);
    else if (b_core_step) b_ts <= tri_next(b_ts);
  end
  assign b_core_z = tri_z(b_ts);

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference for the small instance ----
  // loaded/since: cycles elapsed since the key/IV handshake; acc: bits taken
  // under the current key; q: output bits owed to the sink.
  bit          m_loaded = 0;
  int          m_since = 0;
  int          m_acc = 0;
  bit          q[$];
  logic [79:0] m_key = '0, m_iv = '0;

  always @(negedge clk) begin : monitor
    bit e_kr, e_ld, e_st, e_dr, e_busy, e_exh, warm;
    if (!rst) begin
      check("rst_kiv_ready", 80'(kiv_ready), 80'd0);
      check("rst_dout_valid", 80'(dout_valid), 80'd0);
      check("rst_ks_count", 80'(ks_count), 80'd0);
      check("rst_strobes", 80'({core_load, core_step, din_ready, busy, ks_exh}), 80'd0);
      check("rst_core_key", core_key, 80'd0);
      m_loaded = 0; m_since = 0; m_acc = 0; q.delete(); m_key = '0; m_iv = '0;
    end else begin
      warm   = m_loaded && m_since >= 2 && m_since <= IR + 1;
      e_kr   = (!m_loaded || m_acc == LIM_I) && q.size() == 0 && !abort;
      e_ld   = m_loaded && m_since == 1 && !abort;
      e_dr   = m_loaded && m_since >= IR + 2 && m_acc < LIM_I &&
               (q.size() == 0 || dout_ready) && !abort;
      e_st   = (warm && !abort) || (e_dr && din_valid);
      e_busy = m_loaded && m_since >= 1 && m_since <= IR + 1;
      e_exh  = m_loaded && m_acc == LIM_I;
      check("m_kiv_ready", 80'(kiv_ready), 80'(e_kr));
      check("m_core_load", 80'(core_load), 80'(e_ld));
      check("m_core_step", 80'(core_step), 80'(e_st));
      check("m_din_ready", 80'(din_ready), 80'(e_dr));
      check("m_busy", 80'(busy), 80'(e_busy));
      check("m_ks_exhausted", 80'(ks_exh), 80'(e_exh));
      check("m_dout_valid", 80'(dout_valid), 80'(q.size() != 0));
      if (q.size() != 0) check("m_dout", 80'(dout), 80'(q[0]));
      check("m_ks_count", 80'(ks_count), 80'(m_acc));
      check("m_core_key", core_key, m_key);
      check("m_core_iv", core_iv, m_iv);
      if (abort) begin
        m_loaded = 0; m_since = 0; m_acc = 0; q.delete();
      end else begin
        if (q.size() != 0 && dout_ready) void'(q.pop_front());
        if (e_dr && din_valid) begin
          q.push_back(din ^ zpat[IR + m_acc]);
          m_acc++;
        end
        if (e_kr && kiv_valid) begin
          m_loaded = 1; m_since = 1; m_acc = 0; m_key = key; m_iv = iv;
        end else if (m_loaded) begin
          m_since++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic kv, dv, d, dr, ab;
    logic kr, ld, st, dir, bsy, exh, dvld, dout;
    logic [1:0] ks;
  } vec_t;

  vec_t tbl [14];

  task automatic drive(input logic kv, input logic dv, input logic d,
                       input logic dr, input logic ab);
    @(posedge clk); #1;
    kiv_valid = kv; din_valid = dv; din = d; dout_ready = dr; abort = ab;
    if (kv) begin
      key = {$urandom(), $urandom(), 16'($urandom())};
      iv  = {$urandom(), $urandom(), 16'($urandom())};
    end
  endtask

  initial begin : main
    logic saved;
    int n, steps, ncmp, nacc;
    bit found;
    logic [63:0] ref_z;
    logic [287:0] rs;
    bit bq[$];

    zpat = '1;
    // Columns: kv dv d dr ab | kr ld st dir busy exh dvld dout | ks
    tbl[0]  = 15'b10000_10000000_00;
    tbl[1]  = 15'b00000_01001000_00;
    tbl[2]  = 15'b00000_00101000_00;
    tbl[3]  = 15'b00000_00101000_00;
    tbl[4]  = 15'b00000_00101000_00;
    tbl[5]  = 15'b00000_00101000_00;
    tbl[6]  = 15'b01110_00110000_00;
    tbl[7]  = 15'b01110_00110010_01;
    tbl[8]  = 15'b01110_00110010_10;
    tbl[9]  = 15'b01100_00000110_11;
    tbl[10] = 15'b01100_00000110_11;
    tbl[11] = 15'b00010_00000110_11;
    tbl[12] = 15'b10010_10000100_11;
    tbl[13] = 15'b00000_01001000_00;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Table: load, warm-up, 3-bit budget, exhaustion with a stalled sink, rekey.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].kv, tbl[i].dv, tbl[i].d, tbl[i].dr, tbl[i].ab);
      @(negedge clk);
      check($sformatf("tbl%0d_kiv_ready", i), 80'(kiv_ready), 80'(tbl[i].kr));
      check($sformatf("tbl%0d_core_load", i), 80'(core_load), 80'(tbl[i].ld));
      check($sformatf("tbl%0d_core_step", i), 80'(core_step), 80'(tbl[i].st));
      check($sformatf("tbl%0d_din_ready", i), 80'(din_ready), 80'(tbl[i].dir));
      check($sformatf("tbl%0d_busy", i), 80'(busy), 80'(tbl[i].bsy));
      check($sformatf("tbl%0d_exhausted", i), 80'(ks_exh), 80'(tbl[i].exh));
      check($sformatf("tbl%0d_dout_valid", i), 80'(dout_valid), 80'(tbl[i].dvld));
      if (tbl[i].dvld) check($sformatf("tbl%0d_dout", i), 80'(dout), 80'(tbl[i].dout));
      check($sformatf("tbl%0d_ks_count", i), 80'(ks_count), 80'(tbl[i].ks));
      $display("vec %0d: kv=%b dv=%b din=%b dr=%b ab=%b -> ready=%b load=%b step=%b dready=%b ks=%0d",
               i, kiv_valid, din_valid, din, dout_ready, abort, kiv_ready, core_load,
               core_step, din_ready, ks_count);
    end

    // Back-pressure: one bit taken, sink stalls, output must hold and the core must not step.
    found = 0;
    for (n = 0; n < 20 && !found; n++) begin
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      found = din_ready;
    end
    check("bp_reach_ready", 80'(found), 80'd1);
    drive(0, 1, 0, 0, 0);
    @(negedge clk);
    check("bp_first_taken", 80'(din_ready), 80'd1);
    drive(0, 1, 1, 0, 0);
    @(negedge clk);
    saved = dout;
    check("bp_dout_value", 80'(dout), 80'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0);
      @(negedge clk);
      check("bp_din_ready_low", 80'(din_ready), 80'd0);
      check("bp_no_step", 80'(core_step), 80'd0);
      check("bp_dout_stable", 80'(dout), 80'(saved));
    end
    drive(0, 1, 0, 1, 0);
    @(negedge clk);
    check("bp_resume_step", 80'(core_step), 80'd1);
    $display("bp: stalled dout=%b held, resumed with step=%b", saved, core_step);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    // Abort from READY, reload, abort on the second warm-up step.
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    check("ab_idle_ready", 80'(kiv_ready), 80'd1);
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    check("ab_warm2_no_step", 80'(core_step), 80'd0);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    check("ab_next_no_step", 80'(core_step), 80'd0);
    check("ab_next_ready", 80'(kiv_ready), 80'd1);
    check("ab_next_not_busy", 80'(busy), 80'd0);
    drive(1, 0, 0, 1, 0);
    steps = 0; found = 0;
    for (n = 0; n < 20 && !found; n++) begin
      drive(0, 0, 0, 1, 0);
      @(negedge clk);
      if (core_step) steps++;
      found = din_ready;
    end
    check("ab_reload_ready", 80'(found), 80'd1);
    check("ab_reload_steps", 80'(steps), 80'(IR));
    $display("abort: reload gave %0d warm-up steps", steps);

    // Randomised traffic against the reference, with one mid-run async reset.
    for (int w = 0; w < 8; w++) zpat[w*32 +: 32] = $urandom();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        @(posedge clk); #3 rst = 1'b0;
        #1;
        check("arst_dout_valid", 80'(dout_valid), 80'd0);
        check("arst_ks_count", 80'(ks_count), 80'd0);
        check("arst_strobes", 80'({core_load, core_step, busy, kiv_ready}), 80'd0);
        @(posedge clk); #1 rst = 1'b1;
      end
      drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
      if (c % 500 == 0)
        $display("rand %0d: ks=%0d dout_valid=%b exhausted=%b", c, ks_count, dout_valid, ks_exh);
    end
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);

    // Full Trivium: 1152 warm-up rounds then 64 bits, bit-exact against the reference.
    @(posedge clk); #1;
    b_key = {$urandom(), $urandom(), 16'($urandom())};
    b_iv  = {$urandom(), $urandom(), 16'($urandom())};
    b_kiv_valid = 1'b1;
    @(negedge clk);
    check("big_accept", 80'(b_kiv_ready), 80'd1);
    rs = tri_load(b_key, b_iv);
    for (int r = 0; r < BIG_IR; r++) rs = tri_next(rs);
    for (int i = 0; i < 64; i++) begin
      ref_z[i] = tri_z(rs);
      rs = tri_next(rs);
    end
    ncmp = 0; nacc = 0;
    for (n = 0; n < 3000 && ncmp < 64; n++) begin
      @(posedge clk); #1;
      b_kiv_valid  = 1'b0;
      b_din_valid  = (nacc < 64);
      b_din        = 1'($urandom_range(0, 1));
      b_dout_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (b_dout_valid && b_dout_ready) begin
        if (bq.size() == 0) begin
          check("big_unexpected_dout", 80'd1, 80'd0);
        end else begin
          check($sformatf("big_bit%0d", ncmp), 80'(b_dout), 80'(bq[0]));
          $display("big bit %0d: dout=%b expected=%b", ncmp, b_dout, bq[0]);
          void'(bq.pop_front());
        end
        ncmp++;
      end
      if (b_din_valid && b_din_ready) begin
        bq.push_back(b_din ^ ref_z[nacc]);
        nacc++;
      end
    end
    check("big_all_bits", 80'(ncmp), 80'd64);
    check("big_ks_count", 80'(b_ks_count), 80'd64);
    check("big_state", 80'({b_busy, b_ks_exh}), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
